// File: rtl/pc_trace_pkg.sv
// Shared types and defaults for the PC trace buffer.
package pc_trace_pkg;

    localparam int unsigned PC_XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } trace_state_e;

endpackage

// File: rtl/pc_trace_ram.sv
// Trace storage: DEPTH x XLEN register array, synchronous write, asynchronous read.
module pc_trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/pc_trace_buf.sv
// Circular PC trace buffer: capture until trigger plus post count, then drain oldest-first.
// Optional macro PC_TRACE_DEDUP_EN: only write samples that differ from the last written one.
module pc_trace_buf
    import pc_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = PC_XLEN_DEFAULT,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_pc_debug,
    input  logic            i_arm,
    input  logic            i_abort,
    input  logic [XLEN-1:0] i_trig_pc,
    input  logic [AW-1:0]   i_post_cnt,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_valid,
    input  logic            i_rd_ready,
    output logic            o_rd_last,
    output logic [AW:0]     o_count,
    output logic            o_busy,
    output logic            o_done
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   rem_q, rem_d;
    logic [AW-1:0] post_rem_q, post_rem_d;
    logic          done_q, done_d;
    logic          we;
    logic          match;
    logic          sample_new;
    logic          enter_drain;
    logic [AW-1:0] wr_next;
    logic [AW:0]   count_inc;

`ifdef PC_TRACE_DEDUP_EN
    logic [XLEN-1:0] last_q, last_d;
    logic            have_q, have_d;
`endif

    pc_trace_ram #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (we),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_pc_debug),
        .i_raddr (rd_ptr_q),
        .o_rdata (o_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rem_d       = rem_q;
        post_rem_d  = post_rem_q;
        done_d      = 1'b0;
        we          = 1'b0;
        enter_drain = 1'b0;
        match       = (i_pc_debug == i_trig_pc);
        wr_next     = wr_ptr_q + PTR_ONE;
        count_inc   = (count_q == CNT_FULL) ? count_q : count_q + CNT_ONE;
`ifdef PC_TRACE_DEDUP_EN
        last_d      = last_q;
        have_d      = have_q;
        sample_new  = !have_q || (i_pc_debug != last_q);
`else
        sample_new  = 1'b1;
`endif

        unique case (state_q)
            IDLE: begin
                if (i_arm) begin
                    state_d  = ARMED;
                    wr_ptr_d = '0;
                    count_d  = '0;
`ifdef PC_TRACE_DEDUP_EN
                    have_d   = 1'b0;
`endif
                end
            end
            ARMED: begin
                // Trigger sample is always stored, even if it repeats the previous one.
                we = sample_new || match;
                if (match) begin
                    post_rem_d = i_post_cnt;
                    if (i_post_cnt == '0) begin
                        state_d     = DRAIN;
                        enter_drain = 1'b1;
                    end else begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                we = sample_new;
                if (we) begin
                    post_rem_d = post_rem_q - PTR_ONE;
                    if (post_rem_q == PTR_ONE) begin
                        state_d     = DRAIN;
                        enter_drain = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_rd_ready) begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    rem_d    = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        count_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (we) begin
            wr_ptr_d = wr_next;
            count_d  = count_inc;
`ifdef PC_TRACE_DEDUP_EN
            last_d   = i_pc_debug;
            have_d   = 1'b1;
`endif
        end

        // Oldest entry sits at the next write slot once the buffer has wrapped.
        if (enter_drain) begin
            rd_ptr_d = (count_inc == CNT_FULL) ? wr_next : '0;
            rem_d    = count_inc;
        end

        if (i_abort) begin
            state_d = IDLE;
            count_d = '0;
            done_d  = 1'b0;
            we      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rem_q      <= '0;
            post_rem_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rem_q      <= rem_d;
            post_rem_q <= post_rem_d;
            done_q     <= done_d;
        end
    end

`ifdef PC_TRACE_DEDUP_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            last_q <= '0;
            have_q <= 1'b0;
        end else begin
            last_q <= last_d;
            have_q <= have_d;
        end
    end
`endif

    assign o_rd_valid = (state_q == DRAIN);
    assign o_rd_last  = o_rd_valid && (rem_q == CNT_ONE);
    assign o_count    = count_q;
    assign o_busy     = (state_q != IDLE);
    assign o_done     = done_q;

endmodule

// File: tb/tb_pc_trace_buf.sv
// Self-checking bench for pc_trace_buf against a queue-based capture/drain model.
module tb_pc_trace_buf;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   pc;
    logic          arm;
    logic          abort_in;
    logic [31:0]   trig;
    logic [AW-1:0] post_cnt;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic [AW:0]   count;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [31:0] stim[$];
    logic [31:0] expq[$];

    always #5 clk = ~clk;

    pc_trace_buf #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_pc_debug (pc),
        .i_arm      (arm),
        .i_abort    (abort_in),
        .i_trig_pc  (trig),
        .i_post_cnt (post_cnt),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .i_rd_ready (rd_ready),
        .o_rd_last  (rd_last),
        .o_count    (count),
        .o_busy     (busy),
        .o_done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || count !== '0 || rd_last !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%0b valid=%0b count=%0d last=%0b, required 0/0/0/0",
                     tag, busy, rd_valid, count, rd_last);
        end
    endtask

    // Arms, feeds stim one sample per cycle, and builds the expected trace from the rules.
    task automatic capture(input logic [31:0] t, input logic [AW-1:0] post);
        bit          finished = 0;
        bit          post_phase = 0;
        bit          have = 0;
        logic [31:0] last = '0;
        int          left = 0;
        expq.delete();
        trig = t;
        post_cnt = post;
        arm = 1'b1;
        step();
        arm = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_busy: busy=%0b required 1", busy);
        end
        for (int i = 0; i < stim.size() && !finished; i++) begin
            bit m, wr;
            pc = stim[i];
            step();
            m = !post_phase && (stim[i] == t);
`ifdef PC_TRACE_DEDUP_EN
            wr = !have || (stim[i] != last) || m;
`else
            wr = 1'b1;
`endif
            if (wr) begin
                expq.push_back(stim[i]);
                if (expq.size() > DEPTH) void'(expq.pop_front());
                last = stim[i];
                have = 1;
            end
            if (m) begin
                if (post == 0) finished = 1;
                else begin
                    post_phase = 1;
                    left = int'(post);
                end
            end else if (post_phase && wr) begin
                left--;
                if (left == 0) finished = 1;
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL capture_timeout: stimulus exhausted before capture ended");
        end
        checks++;
        if (rd_valid !== 1'b1 || count !== (AW+1)'(expq.size())) begin
            errors++;
            $display("FAIL drain_entry: valid=%0b count=%0d, required 1/%0d",
                     rd_valid, count, expq.size());
        end
    endtask

    // mode 0: always ready, 1: ready toggles 1010..., 2: random ready.
    task automatic drain(input int mode);
        int          idx = 0;
        int          cyc = 0;
        int          n = expq.size();
        bit          stalled = 0;
        logic [31:0] held = '0;
        bit          rdy;
        while (idx < n && cyc < 400) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            checks++;
            if (rd_valid !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL drain_valid: valid=%0b done=%0b at beat %0d, required 1/0",
                         rd_valid, done, idx);
            end
            if (stalled) begin
                checks++;
                if (rd_data !== held) begin
                    errors++;
                    $display("FAIL stall_hold: data=%h required %h", rd_data, held);
                end
            end
            if (rdy) begin
                checks++;
                if (rd_data !== expq[idx] || rd_last !== (idx == n - 1)) begin
                    errors++;
                    $display("FAIL drain_beat %0d: data=%h last=%0b, required %h/%0b",
                             idx, rd_data, rd_last, expq[idx], (idx == n - 1));
                end
                idx++;
                stalled = 0;
            end else begin
                stalled = 1;
                held = rd_data;
            end
            rd_ready = rdy;
            step();
            cyc++;
        end
        rd_ready = 1'b0;
        checks++;
        if (idx < n) begin
            errors++;
            $display("FAIL drain_timeout: %0d of %0d beats taken", idx, n);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%0b required 1", done);
        end
        check_idle("drain_exit");
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single: done=%0b required 0", done);
        end
    endtask

    task automatic ramp(input logic [31:0] upto);
        stim.delete();
        for (logic [31:0] v = 0; v <= upto; v += 4) stim.push_back(v);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc = '0; arm = 0; abort_in = 0; trig = '0; post_cnt = '0; rd_ready = 0;
        step();
        step();
        check_idle("reset");
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: done=%0b required 0", done);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        ramp(32'h60);
        capture(32'h20, 4'd3);
        drain(0);
    endtask

    task automatic test_wrap();
        ramp(32'h200);
        capture(32'h100, 4'd4);
        drain(0);
    endtask

    task automatic test_post_zero();
        ramp(32'h40);
        capture(32'h8, 4'd0);
        drain(0);
    endtask

    task automatic test_backpressure();
        ramp(32'h60);
        capture(32'h20, 4'd3);
        drain(1);
    endtask

    task automatic test_dedup_stream();
        stim.delete();
        stim.push_back(32'h4); stim.push_back(32'h4);
        stim.push_back(32'h4); stim.push_back(32'h8);
        capture(32'h8, 4'd0);
        drain(2);
    endtask

    task automatic test_abort();
        ramp(32'h60);
        trig = 32'h10; post_cnt = 4'd5;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc = stim[i];
            step();
        end
        abort_in = 1'b1;
        pc = stim[6];
        step();
        abort_in = 1'b0;
        check_idle("abort_post");
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: done=%0b busy=%0b required 0/0", done, busy);
        end
        arm = 1'b1; abort_in = 1'b1;
        step();
        arm = 1'b0; abort_in = 1'b0;
        check_idle("arm_abort_same");
    endtask

    task automatic test_reset_drain();
        ramp(32'h60);
        capture(32'h20, 4'd3);
        rd_ready = 1'b1;
        step();
        step();
        rd_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("reset_drain");
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain_done: done=%0b required 0", done);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [31:0] t = 32'h8000_0000 | ($urandom & 32'h0FFF_FFFC);
            logic [AW-1:0] p = AW'($urandom_range(0, DEPTH - 1));
            int pre = $urandom_range(0, 40);
            stim.delete();
            for (int i = 0; i < pre; i++) stim.push_back(32'h100 + 32'($urandom_range(0, 3)) * 4);
            stim.push_back(t);
            for (int i = 0; i < 200; i++) stim.push_back(32'h100 + 32'($urandom_range(0, 3)) * 4);
            capture(t, p);
            drain(2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_post_zero();
        test_backpressure();
        test_dedup_stream();
        test_abort();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pc_trace_buf.md
Name: pc_trace_buf

Overview:
- Consumer end of the debug PC stream: samples the registered debug PC (`o_pc_debug` of the PC debug register) into a circular trace buffer.
- Stops capturing a programmable number of samples after a PC-match trigger.
- Drains the captured history oldest-first to a host or testbench over a valid/ready read port.
- Sits beside the single-cycle core as a post-mortem debug aid.

Parameters:
- DEPTH, 16, number of trace entries; power of two, ≥ 4.
- XLEN, 32, PC width.
- AW (localparam), $clog2(DEPTH), pointer width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-low.
- i_pc_debug  in  XLEN  registered debug PC from the core.
- i_arm  in  1  pulse; start a capture from IDLE.
- i_abort  in  1  return to IDLE from any state.
- i_trig_pc  in  XLEN  trigger PC value.
- i_post_cnt  in  AW  samples to capture after the trigger sample.
- o_rd_data  out  XLEN  trace entry at the read pointer.
- o_rd_valid  out  1  o_rd_data valid (DRAIN only).
- i_rd_ready  in  1  host accepts o_rd_data.
- o_rd_last  out  1  current entry is the final one.
- o_count  out  AW+1  entries held, saturating at DEPTH.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle pulse after the final drain handshake.

Behaviour:
- Reset (i_clk edge with i_reset=0):
  - state=IDLE.
  - wr_ptr=rd_ptr=0, o_count=0, o_rd_valid=0, o_rd_last=0, o_busy=0, o_done=0.
  - Memory contents are not reset.
- States: IDLE, ARMED, POST, DRAIN.
- IDLE:
  - i_arm=1 → ARMED.
  - wr_ptr and o_count clear on that edge.
- ARMED:
  - Every cycle, writes i_pc_debug to mem[wr_ptr].
  - wr_ptr increments modulo DEPTH (wrap overwrites oldest); o_count increments and saturates at DEPTH.
  - On the match cycle (i_pc_debug==i_trig_pc), the sample is written and post_rem loads i_post_cnt.
  - i_post_cnt==0 → DRAIN; otherwise → POST.
- POST:
  - Writes every cycle; post_rem decrements per written sample.
  - The write with post_rem==1 is the last one → DRAIN.
  - i_trig_pc matches in POST are ignored.
- DRAIN entry:
  - rd_ptr = (o_count==DEPTH) ? wr_ptr : 0, i.e. the oldest entry.
  - rem = o_count.
- DRAIN operation:
  - o_rd_valid=1; o_rd_data=mem[rd_ptr] (combinational read).
  - o_rd_last = (rem==1).
  - Data is held stable while o_rd_valid & !i_rd_ready.
  - Each handshake: rd_ptr++ (mod DEPTH), rem--.
  - Handshake with o_rd_last → IDLE; o_done=1 for the next cycle; o_count clears.
- No writes occur in IDLE or DRAIN.
- i_arm outside IDLE is ignored.
- i_abort → IDLE on the next edge from any state, with no o_done and o_count cleared.
- i_abort and i_arm in the same cycle: abort wins.
- Reset mid-capture or mid-drain behaves like abort plus the reset values above.
- Latency: sample visible in memory the cycle after capture; first drain beat valid the cycle after entering DRAIN.

Optional Feature:
- Macro: PC_TRACE_DEDUP_EN.
- Defined:
  - A sample is written only when it differs from the last written value; the first sample after arm is always written.
  - Suppresses stall loops (e.g. jal x0,0).
  - Trigger compare still runs every ARMED cycle; the trigger sample is always written.
  - post_rem decrements only on written samples.
- Undefined: every ARMED/POST cycle is written.

Decomposition:
- Package pc_trace_pkg:
  - trace_state_e enum (IDLE, ARMED, POST, DRAIN), 2-bit.
  - XLEN default constant.
- Sub-module pc_trace_ram: DEPTH×XLEN register array, one synchronous write port, one asynchronous read port.
- Pointers, counters and FSM stay in pc_trace_buf.

Test Plan (DEPTH=16):
- Reset asserted 2 cycles → o_busy=0, o_rd_valid=0, o_count=0, o_done=0.
- Arm; PC stream 0x0,0x4,…; trig 0x20, post 3 → 12 beats 0x0…0x2C in order, o_rd_last on 0x2C, o_done pulses once.
- Wrap: trig 0x100, post 4, stream 0x0 step 4 → o_count=16, drain 0xD4…0x110.
- Post 0, trig 0x8 → immediate DRAIN, 3 beats 0x0,0x4,0x8.
- Backpressure: i_rd_ready toggling 1010… → o_rd_data stable while stalled, no entry lost or duplicated.
- Abort during POST, and i_reset=0 during DRAIN → IDLE next edge, o_rd_valid=0, no o_done; DEDUP build: stream 0x4,0x4,0x4,0x8 → entries 0x4,0x8 only.
